sc_job_issuer: RTL and testbench
================================

Name: sc_job_issuer

Overview:
- Initiator side of the start/ready/done handshake used by the serial-compute controller.
- Accepts an operand through a valid/ready command port and holds it stable on op_data for the datapath.
- Issues a single-cycle start, tracks the controller through its run, captures the result when done rises, and returns it through a valid/ready response port.
- A watchdog aborts any job whose controller stalls, so the host never hangs.

Parameters:
DATA_W, 8, operand width driven to the datapath
RES_W, 8, result width captured from the datapath
TIMEOUT, 31, maximum cycles allowed in any single waiting state (WAIT_RDY, ARM, RUN); minimum legal value 3

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  host offers an operand
cmd_ready  out  1  issuer can accept an operand (IDLE only)
cmd_data  in  DATA_W  operand
op_data  out  DATA_W  registered operand to the datapath, stable from acceptance until the next acceptance
start  out  1  registered start to the controller
ready_in  in  1  controller ready
done_in  in  1  controller done
result_in  in  RES_W  datapath result, valid while done_in=1
rsp_valid  out  1  response available
rsp_ready  in  1  host takes the response
rsp_data  out  RES_W  captured result (0 on error)
rsp_err  out  1  response is a watchdog abort
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, start=0, op_data=0, rsp_valid=0, rsp_data=0, rsp_err=0, wd_cnt=0.
  - cmd_ready=1 and busy=0 once rst deasserts.
  - Reset mid-job abandons the job with no response.
- Registered outputs: start and all rsp_* are registered. cmd_ready and busy decode from state.
- States and transitions:
  - IDLE: cmd_ready=1. cmd_valid=1 latches cmd_data into op_data and moves to WAIT_RDY.
  - WAIT_RDY: waits for ready_in=1 or done_in=1. done_in counts because a controller parked after a previous job shows done, not ready. On either, moves to ISSUE.
  - ISSUE: start=1 for exactly this one cycle, then moves to ARM. start is never held longer, because a held start keeps the controller parked.
  - ARM: start=0. Waits for ready_in=0 and done_in=0 together (controller has begun counting), then moves to RUN.
  - RUN: waits for done_in=1. On that edge captures result_in into rsp_data, sets rsp_err=0, moves to RESP.
  - RESP: rsp_valid=1; rsp_data and rsp_err held stable. rsp_ready=1 clears rsp_valid and moves to IDLE. The earliest next acceptance is the cycle after.
- Watchdog:
  - wd_cnt clears on every state change and increments each cycle spent in WAIT_RDY, ARM or RUN.
  - When wd_cnt reaches TIMEOUT with the exit condition still false, moves to RESP with rsp_err=1, rsp_data=0, start=0.
  - If the exit condition and the timeout coincide in the same cycle, the normal exit wins.
- Simultaneous events:
  - cmd_valid outside IDLE is ignored (cmd_ready=0).
  - rsp_ready outside RESP is ignored.
  - done_in rising in ARM does not count as completion; ARM must see done_in=0 first, so a stale done from the previous job is never captured.
- Latency: acceptance to start=1 is 2 cycles when the controller is already ready. Start to response depends on the controller run length, plus 1 capture cycle.
- Widths: wd_cnt is ceil(log2(TIMEOUT+1)) bits and saturates, never wraps.

Test Plan:
- Reset then cmd_data=0x5A with controller model idle (ready_in=1):
  - op_data=0x5A the cycle after acceptance.
  - start high exactly 1 cycle, 2 cycles after acceptance.
  - Model raises done_in after 5 count cycles with result_in=0xA5 -> rsp_valid=1, rsp_data=0xA5, rsp_err=0.
- Back-to-back jobs 0x11 then 0x22, controller parked in done (ready_in=0, done_in=1) -> second job issues start from done.
  - The stale done is not captured.
  - Second response equals the model's result for 0x22.
- rsp_ready held low 10 cycles -> rsp_valid, rsp_data, rsp_err stable throughout; cmd_ready=0 throughout.
- Controller model never asserts done_in, TIMEOUT=31 -> rsp_valid=1, rsp_err=1, rsp_data=0 exactly 31 cycles after entering RUN; busy returns 0 after rsp_ready.
- rst pulsed high while in RUN -> all outputs at reset values immediately. Late done_in=1 from the model after reset produces no response.
- cmd_valid asserted while busy -> no acceptance and op_data unchanged until IDLE.

Source files
------------

// File: rtl/sc_job_issuer.sv
// rtl/sc_job_issuer.sv - start/ready/done initiator with operand hold, result capture and watchdog abort
module sc_job_issuer #(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 8,
    parameter int TIMEOUT = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] op_data,
    output logic              start,
    input  logic              ready_in,
    input  logic              done_in,
    input  logic [RES_W-1:0]  result_in,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_ISSUE,
        S_ARM,
        S_RUN,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WD_W-1:0]     r_wd_cnt;
    logic [DATA_W-1:0]   r_op_data;
    logic                r_start;
    logic                r_rsp_valid;
    logic [RES_W-1:0]    r_rsp_data;
    logic                r_rsp_err;
    logic                w_wait_state;
    logic                w_exit;
    logic                w_timeout;

    always_comb begin
        w_next       = r_state;
        w_wait_state = 1'b0;
        w_exit       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE:     if (cmd_valid) w_next = S_WAIT_RDY;
            S_WAIT_RDY: begin
                // A controller parked after a previous job shows done, not ready.
                w_wait_state = 1'b1;
                w_exit       = ready_in | done_in;
                if (w_exit) w_next = S_ISSUE;
            end
            S_ISSUE:    w_next = S_ARM;
            S_ARM: begin
                w_wait_state = 1'b1;
                w_exit       = !ready_in && !done_in;
                if (w_exit) w_next = S_RUN;
            end
            S_RUN: begin
                w_wait_state = 1'b1;
                w_exit       = done_in;
                if (w_exit) w_next = S_RESP;
            end
            S_RESP:     if (rsp_ready) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
        // The cycle in which the count would reach TIMEOUT is the last one allowed.
        w_timeout = w_wait_state && !w_exit && (r_wd_cnt >= WD_LAST);
        if (w_timeout) w_next = S_RESP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wd_cnt    <= '0;
            r_op_data   <= '0;
            r_start     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_start <= (w_next == S_ISSUE);

            if (w_next != r_state)
                r_wd_cnt <= '0;
            else if (w_wait_state && r_wd_cnt != WD_MAX)
                r_wd_cnt <= r_wd_cnt + 1'b1;

            if (r_state == S_IDLE && cmd_valid)
                r_op_data <= cmd_data;

            if (r_state == S_RUN && done_in) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= result_in;
                r_rsp_err   <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= '0;
                r_rsp_err   <= 1'b1;
            end else if (r_state == S_RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign op_data   = r_op_data;
    assign start     = r_start;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_sc_job_issuer.sv
// tb/tb_sc_job_issuer.sv - directed vector bench for sc_job_issuer with a behavioural controller model
module tb_sc_job_issuer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] op_data;
    logic       start;
    logic       ready_in = 1'b1;
    logic       done_in = 1'b0;
    logic [7:0] result_in = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    sc_job_issuer #(.DATA_W(8), .RES_W(8), .TIMEOUT(31)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .op_data(op_data), .start(start),
        .ready_in(ready_in), .done_in(done_in), .result_in(result_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Controller model: parks ready, counts m_len cycles after start, then parks in done with ~operand.
    bit m_hang = 1'b0;
    bit m_reset = 1'b0;
    bit m_busy = 1'b0;
    int m_len = 5;
    int m_cnt = 0;

    always @(negedge clk) begin
        if (m_reset) begin
            ready_in = 1'b1;
            done_in  = 1'b0;
            m_busy   = 1'b0;
            m_cnt    = 0;
        end else if (start) begin
            ready_in = 1'b0;
            done_in  = 1'b0;
            m_busy   = 1'b1;
            m_cnt    = 0;
        end else if (m_busy && !m_hang) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == m_len) begin
                done_in   = 1'b1;
                result_in = ~op_data;
                m_busy    = 1'b0;
            end
        end
    end

    typedef struct {
        logic [7:0] op;
        int         len;
        logic [7:0] exp_res;
        int         exp_lat;
        int         hold;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic accept(input logic [7:0] op, output int s, output bit seen);
        int c;
        cmd_data  = op;
        cmd_valid = 1'b1;
        c = cyc;
        tick;
        cmd_valid = 1'b0;
        check("op_data_after_accept", op_data, op);
        seen = 1'b0;
        s = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (start) begin
                seen = 1'b1;
                s = cyc;
            end else begin
                tick;
            end
        end
        check("start_seen", seen, 1);
        check("accept_to_start", s - c, 2);
        tick;
        check("start_one_cycle", start, 0);
    endtask

    task automatic run_job(input logic [7:0] op, input int len, input logic [7:0] exp_res,
                           input int exp_lat, input int hold);
        int  s, r;
        bit  seen;
        m_len = len;
        accept(op, s, seen);
        seen = 1'b0;
        r = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                r = cyc;
            end else begin
                tick;
            end
        end
        check("rsp_seen", seen, 1);
        check("start_to_rsp", r - s, exp_lat);
        check("rsp_data", rsp_data, exp_res);
        check("rsp_err", rsp_err, 0);
        check("busy_in_resp", busy, 1);
        for (int h = 0; h < hold; h++) begin
            cmd_data  = 8'h77;
            cmd_valid = 1'b1;
            tick;
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_data", rsp_data, exp_res);
            check("hold_rsp_err", rsp_err, 0);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_op_data", op_data, op);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("rsp_valid_cleared", rsp_valid, 0);
        check("busy_after_rsp", busy, 0);
        check("cmd_ready_after_rsp", cmd_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        int  s;
        bit  seen;
        bit  stray;

        vecs[0] = '{8'h5A, 5, 8'hA5, 6, 0};
        vecs[1] = '{8'h11, 3, 8'hEE, 4, 0};
        vecs[2] = '{8'h22, 4, 8'hDD, 5, 10};
        vecs[3] = '{8'hFF, 2, 8'h00, 3, 0};
        vecs[4] = '{8'h00, 6, 8'hFF, 7, 0};
        vecs[5] = '{8'hC3, 7, 8'h3C, 8, 0};

        tick;
        tick;
        check("rst_op_data", op_data, 0);
        check("rst_start", start, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick;
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_busy", busy, 0);

        for (int i = 0; i < 6; i++)
            run_job(vecs[i].op, vecs[i].len, vecs[i].exp_res, vecs[i].exp_lat, vecs[i].hold);

        // Reset in RUN: job abandoned, late done must not produce a response.
        m_len = 20;
        accept(8'h6B, s, seen);
        tick;
        tick;
        tick;
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_start", start, 0);
        check("midrst_op_data", op_data, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rsp_data", rsp_data, 0);
        check("midrst_rsp_err", rsp_err, 0);
        check("midrst_busy", busy, 0);
        tick;
        rst = 1'b0;
        tick;
        check("midrst_cmd_ready", cmd_ready, 1);
        stray = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (rsp_valid || busy || start) stray = 1'b1;
        end
        check("late_done_ignored", stray, 0);
        check("late_done_seen_by_model", done_in, 1);

        // Watchdog: controller never finishes; response lands 31 cycles after RUN entry (s+2).
        m_hang = 1'b1;
        accept(8'h3C, s, seen);
        while (cyc < s + 32) tick;
        check("wd_not_early", rsp_valid, 0);
        tick;
        check("wd_rsp_valid", rsp_valid, 1);
        check("wd_rsp_err", rsp_err, 1);
        check("wd_rsp_data", rsp_data, 0);
        check("wd_start_low", start, 0);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("wd_busy_after_rsp", busy, 0);
        m_hang  = 1'b0;
        m_reset = 1'b1;
        tick;
        m_reset = 1'b0;

        run_job(8'h81, 4, 8'h7E, 5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
